// File: rtl/mult_arbiter.sv
// Round-robin arbiter that sequences NUM_REQ requesters onto one shared multiplier.
// Optional macro MULT_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts and pulses mult_reset_n.
//
// state | meaning
// IDLE  | pick round-robin winner, accept its operands
// ISSUE | hold mult_start with captured operands until mult_ready
// BUSY  | wait for mult_done (or watchdog expiry)
// RESP  | present product to the granted requester until rsp_ready
module mult_arbiter #(
    parameter int WIDTH          = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
    input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     rsp_err,
    output logic                     mult_reset_n,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_multiplicand,
    output logic [WIDTH-1:0]         mult_multiplier,
    input  logic                     mult_ready,
    input  logic                     mult_done,
    input  logic [2*WIDTH-1:0]       mult_product
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               win_found;
    logic [GW-1:0]      win_idx;
    logic [GW-1:0]      cand;
    logic [WIDTH-1:0]   win_mcand;
    logic [WIDTH-1:0]   win_mplier;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic          rsp_err_q, rsp_err_d;
    logic          mult_rst_q, mult_rst_d;
`else
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Search starts one past the last completed grant, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_mcand  = '0;
        win_mplier = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_mcand  = req_multiplicand[i*WIDTH +: WIDTH];
                win_mplier = req_multiplier[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        product_d    = product_q;
`ifdef MULT_ARB_TIMEOUT_EN
        busy_cnt_d   = busy_cnt_q;
        rsp_err_d    = rsp_err_q;
        mult_rst_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d  = win_idx;
                    mcand_d  = win_mcand;
                    mplier_d = win_mplier;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mult_ready) begin
                    state_d = S_BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
                    busy_cnt_d = CNT_LOAD;
`endif
                end
            end
            S_BUSY: begin
                // A done arriving on the expiry cycle wins over the watchdog.
                if (mult_done) begin
                    product_d = mult_product;
                    state_d   = S_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (busy_cnt_q == '0) begin
                    product_d  = '0;
                    rsp_err_d  = 1'b1;
                    mult_rst_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    busy_cnt_d = busy_cnt_q - CW'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            product_q    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            busy_cnt_q   <= '0;
            rsp_err_q    <= 1'b0;
            mult_rst_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            product_q    <= product_d;
`ifdef MULT_ARB_TIMEOUT_EN
            busy_cnt_q   <= busy_cnt_d;
            rsp_err_q    <= rsp_err_d;
            mult_rst_q   <= mult_rst_d;
`endif
        end
    end

    // req_ready is gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset_n && state_q == S_IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    assign mult_start        = (state_q == S_ISSUE);
    assign mult_multiplicand = mcand_q;
    assign mult_multiplier   = mplier_q;
    assign rsp_product       = product_q;

`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
    assign mult_reset_n = reset_n & ~mult_rst_q;
`else
    assign rsp_err      = 1'b0;
    assign mult_reset_n = reset_n;
`endif

endmodule
